// File: rtl/mri_sequencer.sv
// Self-timed sequencer for the PDP-8 memory-reference instructions (AND, TAD, ISZ, DCA, JMS, JMP).
// Define AUTOINDEX_EN to give isPPIND two auto-index pre-increment steps; otherwise isPPIND runs as isIND.
module mri_sequencer #(
  parameter int CK_CYCLES  = 1,
  parameter int STB_CYCLES = 1,
  parameter int STEP_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic              isDIR,
  input  logic              isIND,
  input  logic              isPPIND,
  input  logic              incZero,
  output logic              ir2rama,
  output logic              ind2rama,
  output logic              ram_oe,
  output logic              ramd2ac_and,
  output logic              ramd2ac_add,
  output logic              ac2ramd,
  output logic              pc2ramd,
  output logic              inc2ramd,
  output logic              ld2inc,
  output logic              cla,
  output logic              rot2ac,
  output logic              ir2pc,
  output logic              ind2reg,
  output logic              reg2pc,
  output logic              ac_ck,
  output logic              link_ck,
  output logic              data_ck,
  output logic              ram_we,
  output logic              pc_ck,
  output logic              pc_ld,
  output logic              ind_ck,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [STEP_W-1:0] step
);

  typedef enum logic [1:0] {IDLE, CK, STB, DONE} state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;

  localparam logic [1:0] CK_LAST  = 2'(CK_CYCLES - 1);
  localparam logic [1:0] STB_LAST = 2'(STB_CYCLES - 1);

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [2:0]          op_q, op_d;
  logic                dir_q, dir_d;
  logic                auto_q, auto_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;

  logic [2:0]          mode;
  logic                legal;
  logic [STEP_W-1:0]   last_step;
  logic [STEP_W-1:0]   lstep;
  logic                active;
  logic                stb;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      step_q    <= '0;
      op_q      <= '0;
      dir_q     <= 1'b0;
      auto_q    <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      op_q      <= op_d;
      dir_q     <= dir_d;
      auto_q    <= auto_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    mode  = {isDIR, isIND, isPPIND};
    legal = (opcode <= OP_JMP) && ((mode == 3'b100) || (mode == 3'b010) || (mode == 3'b001));

    case (op_q)
      OP_ISZ, OP_JMS: last_step = STEP_W'(3);
      OP_DCA:         last_step = STEP_W'(2);
      default:        last_step = STEP_W'(1);
    endcase
    if (auto_q) last_step = last_step + STEP_W'(2);

    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    op_d      = op_q;
    dir_d     = dir_q;
    auto_d    = auto_q;
    zero_d    = zero_q;
    illegal_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && legal) begin
          state_d = CK;
          cnt_d   = '0;
          step_d  = STEP_W'(1);
          op_d    = opcode;
          dir_d   = isDIR;
`ifdef AUTOINDEX_EN
          auto_d  = isPPIND;
`else
          auto_d  = 1'b0;
`endif
        end else if (start) begin
          illegal_d = 1'b1;
        end
      end
      CK: begin
        if (cnt_q == CK_LAST) begin
          state_d = STB;
          cnt_d   = '0;
          zero_d  = incZero;  // ISZ skip decision is frozen at STB entry
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      STB: begin
        if (cnt_q == STB_LAST) begin
          cnt_d = '0;
          if (step_q == last_step) begin
            state_d = DONE;
          end else begin
            state_d = CK;
            step_d  = step_q + STEP_W'(1);
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  always_comb begin
    {ir2rama, ind2rama, ram_oe, ramd2ac_and, ramd2ac_add, ac2ramd, pc2ramd,
     inc2ramd, ld2inc, cla, rot2ac, ir2pc, ind2reg, reg2pc} = '0;
    {ac_ck, link_ck, data_ck, ram_we, pc_ck, pc_ld, ind_ck} = '0;
    active  = (state_q == CK) || (state_q == STB);
    stb     = (state_q == STB);
    lstep   = auto_q ? step_q - STEP_W'(2) : step_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    illegal = illegal_q;
    step    = step_q;

    if (active) begin
      if (auto_q && step_q == STEP_W'(1)) begin
        ir2rama = 1'b1;
        ram_oe  = 1'b1;
        data_ck = stb;
      end else if (auto_q && step_q == STEP_W'(2)) begin
        ir2rama  = 1'b1;
        inc2ramd = 1'b1;
        ld2inc   = 1'b1;
        ram_we   = stb;
`ifdef AUTOINDEX_EN
        ind_ck   = stb;
`endif
      end else begin
        // After auto-index, dir_q is low so the main steps address through the pointer.
        case (op_q)
          OP_AND: begin
            {ir2rama, ind2rama} = {dir_q, !dir_q};
            ram_oe      = 1'b1;
            ramd2ac_and = 1'b1;
            ac_ck       = stb;
          end
          OP_TAD: begin
            {ir2rama, ind2rama} = {dir_q, !dir_q};
            ram_oe      = 1'b1;
            ramd2ac_add = 1'b1;
            ac_ck       = stb;
            link_ck     = stb;
          end
          OP_ISZ: begin
            if (lstep == STEP_W'(1)) begin
              {ir2rama, ind2rama} = {dir_q, !dir_q};
              ram_oe  = 1'b1;
              data_ck = stb;
            end else if (lstep == STEP_W'(2)) begin
              {ir2rama, ind2rama} = {dir_q, !dir_q};
              inc2ramd = 1'b1;
              ld2inc   = 1'b1;
              ram_we   = stb;
            end else begin
              ld2inc = 1'b1;
              pc_ck  = stb && zero_q;
            end
          end
          OP_DCA: begin
            if (lstep == STEP_W'(1)) begin
              {ir2rama, ind2rama} = {dir_q, !dir_q};
              ac2ramd = 1'b1;
              ram_we  = stb;
            end else begin
              cla    = 1'b1;
              rot2ac = 1'b1;
              ac_ck  = stb;
            end
          end
          OP_JMS: begin
            if (lstep == STEP_W'(1)) begin
              {ir2rama, ind2rama} = {dir_q, !dir_q};
              pc2ramd = 1'b1;
              ram_we  = stb;
            end else if (lstep == STEP_W'(2)) begin
              {ir2pc, ind2reg, reg2pc} = {dir_q, !dir_q, !dir_q};
              pc_ld = stb;
            end else begin
              pc_ck = stb;
            end
          end
          default: begin
            {ir2pc, ind2reg, reg2pc} = {dir_q, !dir_q, !dir_q};
            pc_ld = stb;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mri_sequencer.sv
// Bench for mri_sequencer: a unit-phase and a stretched-phase instance run side by side against
// a step-table model that expands each instruction into per-cycle expected output vectors.
module tb_mri_sequencer;

  localparam int CKA = 1;
  localparam int SBA = 1;
  localparam int CKB = 2;
  localparam int SBB = 3;
`ifdef AUTOINDEX_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef logic [23:0] vec_t;

  localparam vec_t V_IR2RAMA  = vec_t'(1) << 0;
  localparam vec_t V_IND2RAMA = vec_t'(1) << 1;
  localparam vec_t V_RAM_OE   = vec_t'(1) << 2;
  localparam vec_t V_D2AC_AND = vec_t'(1) << 3;
  localparam vec_t V_D2AC_ADD = vec_t'(1) << 4;
  localparam vec_t V_AC2RAMD  = vec_t'(1) << 5;
  localparam vec_t V_PC2RAMD  = vec_t'(1) << 6;
  localparam vec_t V_INC2RAMD = vec_t'(1) << 7;
  localparam vec_t V_LD2INC   = vec_t'(1) << 8;
  localparam vec_t V_CLA      = vec_t'(1) << 9;
  localparam vec_t V_ROT2AC   = vec_t'(1) << 10;
  localparam vec_t V_IR2PC    = vec_t'(1) << 11;
  localparam vec_t V_IND2REG  = vec_t'(1) << 12;
  localparam vec_t V_REG2PC   = vec_t'(1) << 13;
  localparam vec_t V_AC_CK    = vec_t'(1) << 14;
  localparam vec_t V_LINK_CK  = vec_t'(1) << 15;
  localparam vec_t V_DATA_CK  = vec_t'(1) << 16;
  localparam vec_t V_RAM_WE   = vec_t'(1) << 17;
  localparam vec_t V_PC_CK    = vec_t'(1) << 18;
  localparam vec_t V_PC_LD    = vec_t'(1) << 19;
  localparam vec_t V_IND_CK   = vec_t'(1) << 20;
  localparam vec_t V_BUSY     = vec_t'(1) << 21;
  localparam vec_t V_DONE     = vec_t'(1) << 22;
  localparam vec_t V_ILLEGAL  = vec_t'(1) << 23;

  logic       clk, reset, start, isDIR, isIND, isPPIND, incZero;
  logic [2:0] opcode;
  vec_t       oa, ob;
  logic [2:0] sa, sb;

  int n_checks = 0;
  int n_pass   = 0;

  mri_sequencer #(.CK_CYCLES(CKA), .STB_CYCLES(SBA), .STEP_W(3)) dut_a (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .isDIR(isDIR), .isIND(isIND),
    .isPPIND(isPPIND), .incZero(incZero),
    .ir2rama(oa[0]), .ind2rama(oa[1]), .ram_oe(oa[2]), .ramd2ac_and(oa[3]), .ramd2ac_add(oa[4]),
    .ac2ramd(oa[5]), .pc2ramd(oa[6]), .inc2ramd(oa[7]), .ld2inc(oa[8]), .cla(oa[9]),
    .rot2ac(oa[10]), .ir2pc(oa[11]), .ind2reg(oa[12]), .reg2pc(oa[13]),
    .ac_ck(oa[14]), .link_ck(oa[15]), .data_ck(oa[16]), .ram_we(oa[17]), .pc_ck(oa[18]),
    .pc_ld(oa[19]), .ind_ck(oa[20]), .busy(oa[21]), .done(oa[22]), .illegal(oa[23]), .step(sa)
  );

  mri_sequencer #(.CK_CYCLES(CKB), .STB_CYCLES(SBB), .STEP_W(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .isDIR(isDIR), .isIND(isIND),
    .isPPIND(isPPIND), .incZero(incZero),
    .ir2rama(ob[0]), .ind2rama(ob[1]), .ram_oe(ob[2]), .ramd2ac_and(ob[3]), .ramd2ac_add(ob[4]),
    .ac2ramd(ob[5]), .pc2ramd(ob[6]), .inc2ramd(ob[7]), .ld2inc(ob[8]), .cla(ob[9]),
    .rot2ac(ob[10]), .ir2pc(ob[11]), .ind2reg(ob[12]), .reg2pc(ob[13]),
    .ac_ck(ob[14]), .link_ck(ob[15]), .data_ck(ob[16]), .ram_we(ob[17]), .pc_ck(ob[18]),
    .pc_ld(ob[19]), .ind_ck(ob[20]), .busy(ob[21]), .done(ob[22]), .illegal(ob[23]), .step(sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an instruction is a list of steps, each a select set held for CK+STB and a strobe set for STB.
  vec_t m_sel[8];
  vec_t m_stb[8];
  int   m_n;

  task automatic add_step(input vec_t s, input vec_t t);
    m_sel[m_n] = s;
    m_stb[m_n] = t;
    m_n++;
  endtask

  task automatic model_steps(input logic [2:0] op, input bit d, input bit pp, input bit incz);
    vec_t rama, ipc;
    rama = d ? V_IR2RAMA : V_IND2RAMA;
    ipc  = d ? V_IR2PC : (V_IND2REG | V_REG2PC);
    m_n  = 0;
    if (AUTO && pp) begin
      add_step(V_IR2RAMA | V_RAM_OE, V_DATA_CK);
      add_step(V_IR2RAMA | V_INC2RAMD | V_LD2INC, V_RAM_WE | V_IND_CK);
    end
    case (op)
      3'd0: add_step(rama | V_RAM_OE | V_D2AC_AND, V_AC_CK);
      3'd1: add_step(rama | V_RAM_OE | V_D2AC_ADD, V_AC_CK | V_LINK_CK);
      3'd2: begin
        add_step(rama | V_RAM_OE, V_DATA_CK);
        add_step(rama | V_INC2RAMD | V_LD2INC, V_RAM_WE);
        add_step(V_LD2INC, incz ? V_PC_CK : '0);
      end
      3'd3: begin
        add_step(rama | V_AC2RAMD, V_RAM_WE);
        add_step(V_CLA | V_ROT2AC, V_AC_CK);
      end
      3'd4: begin
        add_step(rama | V_PC2RAMD, V_RAM_WE);
        add_step(ipc, V_PC_LD);
        add_step('0, V_PC_CK);
      end
      default: add_step(ipc, V_PC_LD);
    endcase
  endtask

  // Expected outputs at cycle T+1+i; stp < 0 means step is not compared in that cycle.
  function automatic vec_t expect_at(input int ck, input int sbc, input int i, input bit legal,
                                     output int stp);
    int per, total;
    per   = ck + sbc;
    total = m_n * per;
    stp   = 0;
    if (!legal) return (i == 0) ? V_ILLEGAL : '0;
    if (i < total) begin
      stp = i / per + 1;
      return m_sel[i / per] | V_BUSY | (((i % per) >= ck) ? m_stb[i / per] : '0);
    end
    if (i == total) begin
      stp = -1;
      return V_BUSY | V_DONE;
    end
    return '0;
  endfunction

  // Called at a negedge in an idle cycle; returns at the negedge of the first idle cycle after it.
  task automatic run_txn(input string name, input logic [2:0] op, input bit d, input bit ind,
                         input bit pp, input bit incz, input bit junk);
    bit   legal;
    int   len_a, len_b, pa, pb;
    vec_t ea, eb;
    legal = (op <= 3'd5) && ((int'(d) + int'(ind) + int'(pp)) == 1);
    model_steps(op, d, pp, incz);
    len_a = legal ? m_n * (CKA + SBA) + 1 : 1;
    len_b = legal ? m_n * (CKB + SBB) + 1 : 1;
    opcode = op; isDIR = d; isIND = ind; isPPIND = pp; incZero = incz; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i <= len_b; i++) begin
      @(negedge clk);
      ea = expect_at(CKA, SBA, i, legal, pa);
      eb = expect_at(CKB, SBB, i, legal, pb);
      n_checks++;
      if (oa !== ea) $display("FAIL %s unit-phase outputs T+%0d: got %h want %h", name, i + 1, oa, ea);
      else n_pass++;
      n_checks++;
      if (ob !== eb) $display("FAIL %s stretched outputs T+%0d: got %h want %h", name, i + 1, ob, eb);
      else n_pass++;
      if (pa >= 0) begin
        n_checks++;
        if (sa !== 3'(pa)) $display("FAIL %s unit-phase step T+%0d: got %0d want %0d", name, i + 1, sa, pa);
        else n_pass++;
      end
      if (pb >= 0) begin
        n_checks++;
        if (sb !== 3'(pb)) $display("FAIL %s stretched step T+%0d: got %0d want %0d", name, i + 1, sb, pb);
        else n_pass++;
      end
      // While both instances are busy, wiggle the inputs: they must be ignored.
      if (junk && legal && i < len_a - 1) begin
        start   = 1'($urandom);
        opcode  = 3'($urandom);
        isDIR   = 1'($urandom);
        isIND   = 1'($urandom);
        isPPIND = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opcode = '0;
    isDIR = 1'b0; isIND = 1'b0; isPPIND = 1'b0; incZero = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (oa !== '0 || ob !== '0) $display("FAIL reset_outputs: got %h/%h want 0", oa, ob);
    else n_pass++;
    n_checks++;
    if (sa !== 3'd0 || sb !== 3'd0) $display("FAIL reset_step: got %0d/%0d want 0", sa, sb);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (oa !== '0 || ob !== '0) $display("FAIL post_reset_idle: got %h/%h want 0", oa, ob);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_txn("and_dir", 3'd0, 1, 0, 0, 0, 0);
    run_txn("isz_ind_z1", 3'd2, 0, 1, 0, 1, 0);
    run_txn("isz_ind_z0", 3'd2, 0, 1, 0, 0, 0);
    run_txn("dca_dir", 3'd3, 1, 0, 0, 0, 0);
    run_txn("tad_ppind", 3'd1, 0, 0, 1, 0, 0);
    run_txn("jms_ppind", 3'd4, 0, 0, 1, 1, 0);
  endtask

  task automatic test_illegal();
    run_txn("illegal_op6", 3'd6, 1, 0, 0, 0, 0);
    run_txn("illegal_op7", 3'd7, 0, 1, 0, 0, 0);
    run_txn("illegal_two_modes", 3'd0, 1, 1, 0, 0, 0);
    run_txn("illegal_no_mode", 3'd5, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    opcode = 3'd4; isDIR = 1'b1; isIND = 1'b0; isPPIND = 1'b0; incZero = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (oa[19] !== 1'b1) $display("FAIL jms_stb2_pc_ld: got %b want 1", oa[19]);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (oa !== '0 || ob !== '0) $display("FAIL async_reset_outputs: got %h/%h want 0", oa, ob);
    else n_pass++;
    n_checks++;
    if (sa !== 3'd0 || sb !== 3'd0) $display("FAIL async_reset_step: got %0d/%0d want 0", sa, sb);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (oa !== '0 || ob !== '0) $display("FAIL after_reset_idle: got %h/%h want 0", oa, ob);
    else n_pass++;
    run_txn("jmp_ind_after_reset", 3'd5, 0, 1, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_and", 3'd0, 0, 1, 0, 0, 0);
    run_txn("b2b_jmp", 3'd5, 1, 0, 0, 0, 0);
    run_txn("b2b_dca", 3'd3, 0, 0, 1, 0, 0);
    run_txn("b2b_isz", 3'd2, 1, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [2:0] op, m;
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      if ($urandom_range(0, 9) < 8) m = 3'b001 << $urandom_range(0, 2);
      else m = 3'($urandom);
      run_txn("random", op, m[2], m[1], m[0], 1'($urandom), 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
